pingpong_transposer: RTL and testbench
======================================

Name: pingpong_transposer

Overview:
- Sits directly downstream of the matrix-multiply memory controller, between its left/right data outputs and the systolic array edge.
- Accepts 64-bit words, each four 16-bit matrix elements forming one row of a 4x4 block, into one of two register banks.
- While one bank fills, the other is drained column by column, so a stream of row words becomes a stream of transposed column words at full rate, one word per cycle.
- Bank selection ping-pongs automatically on each completed block.

Parameters:
- EW, 16: element width in bits.
- N, 4: block dimension; data word width is N*EW = 64.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- clear  input  1  synchronous clear of counters, banks, valid flags and bank select; tied to calc_init.
- in_valid  input  1  in_data carries a row word this cycle.
- in_data  input  64  row word; element c occupies bits [16c+15:16c].
- dir  input  1  column emission order: 0 = columns 0..N-1, 1 = columns N-1..0.
- out_valid  output  1  out_data carries a column word.
- out_data  output  64  column word; lane k = element(row k, current column); all zeros when out_valid=0.
- wr_bank  output  1  bank currently being written.
- rd_bank_busy  output  1  the read bank is draining.

Behaviour:
- Reset or clear:
  - out_valid=0, out_data=0, wr_bank=0, rd_bank_busy=0.
  - wr_cnt=0, rd_cnt=0; both bank-full flags=0.
  - Bank contents need not be zeroed.
  - clear has priority over in_valid in the same cycle; that word is discarded.
- Write side:
  - Each cycle with in_valid=1, in_data is stored as row wr_cnt of bank wr_bank, then wr_cnt increments (2-bit, wraps 3->0).
  - On acceptance with wr_cnt==N-1: set full[wr_bank], toggle wr_bank, start read of the completed bank.
  - The same clock edge also samples dir into dir_q for that block.
- Read side FSM:
  - States RD_IDLE and RD_DRAIN.
  - RD_IDLE -> RD_DRAIN on block completion.
  - In RD_DRAIN, each cycle outputs registered column col, then rd_cnt++.
    - col = rd_cnt when dir_q=0.
    - col = N-1-rd_cnt when dir_q=1.
  - After rd_cnt==N-1 is emitted: clear full[rd_bank], rd_cnt=0.
    - If another block completed on that same edge, stay in RD_DRAIN on the new bank with a newly sampled dir_q.
    - Otherwise go to RD_IDLE.
- Latency:
  - The first column word is registered on the edge after the last row word is accepted: 1 cycle from last word, N cycles from first word of a gapless block.
  - Back-to-back blocks give continuous out_valid.
- No backpressure:
  - A block takes at least N cycles to write and exactly N cycles to drain, so the write bank is always free when written.
  - A write into a bank whose full flag is set is a protocol error. That word is dropped and the sticky internal flag ovf is set (visible in simulation only).
- Input gaps:
  - in_valid low mid-block simply pauses wr_cnt.
  - A partial block is held indefinitely until completed or cleared.
- dir changes mid-block do not affect a block already draining.
- Arithmetic: pure data movement; no element modification; no width change.
- Reset mid-operation: all in-flight blocks are lost and outputs drop to zero immediately (asynchronous).

Optional Feature:
- Macro: TRANSPOSER_BYPASS_EN.
- When defined:
  - Adds input port bypass (1 bit), sampled with dir at block completion.
  - If bypass was 1, the drain emits rows instead of columns, row order following dir_q; timing is identical.
  - Used for passing weights that are already laid out in column order.
- When undefined: the port is absent and every block is transposed.

Test Plan:
- Transpose, dir=0: rows 0x0003000200010000, 0x0007000600050004, 0x000B000A00090008, 0x000F000E000D000C on consecutive cycles.
  - out_valid rises 1 cycle after row 3.
  - Outputs: 0x000C000800040000, 0x000D000900050001, 0x000E000A00060002, 0x000F000B00070003.
- Same block with dir=1 -> first output 0x000F000B00070003, last 0x000C000800040000.
- Two back-to-back blocks (8 consecutive words):
  - wr_bank toggles 0->1->0.
  - out_valid high for 8 consecutive cycles.
  - The second block drains from bank 1 with no bubble.
- Gapped input: the same block with in_valid low for 3 cycles between rows 1 and 2 -> identical outputs; out_valid stays 0 until row 3 is accepted.
- Clear and reset mid-block:
  - clear asserted with in_valid after 2 rows -> that word is discarded and wr_cnt=0.
  - The next 4 rows form a clean block with correct transposition.
  - rst_n pulsed during drain -> out_valid=0 and out_data=0 immediately.
- With TRANSPOSER_BYPASS_EN, bypass=1, dir=0: the row block above -> outputs equal the input rows in order 0..3.

Source files
------------

// File: rtl/pingpong_transposer.sv
// Ping-pong 4x4 block transposer: row words fill one bank while the other drains as column words.
// Optional TRANSPOSER_BYPASS_EN adds a bypass input that makes a block drain as rows instead.
module pingpong_transposer #(
   parameter int EW = 16,
   parameter int N  = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   input  logic            in_valid,
   input  logic [N*EW-1:0] in_data,
   input  logic            dir,
`ifdef TRANSPOSER_BYPASS_EN
   input  logic            bypass,
`endif
   output logic            out_valid,
   output logic [N*EW-1:0] out_data,
   output logic            wr_bank,
   output logic            rd_bank_busy
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic {RD_IDLE, RD_DRAIN} rd_state_t;

   rd_state_t       state_q, state_d;
   logic [N*EW-1:0] bank [2][N];
   logic [CW-1:0]   wr_cnt, rd_cnt, sel;
   logic [1:0]      full;
   logic            rd_bank, dir_q, ovf;
   logic            accept, blk_done, last_col, load;
   logic [N*EW-1:0] col_word;
`ifdef TRANSPOSER_BYPASS_EN
   logic            bypass_q;
`endif

   assign accept       = in_valid && !clear && !full[wr_bank];
   assign blk_done     = accept && (wr_cnt == LAST);
   assign last_col     = (state_q == RD_DRAIN) && (rd_cnt == LAST);
   // A completed block starts draining either from idle or seamlessly after the last column.
   assign load         = blk_done && ((state_q == RD_IDLE) || last_col);
   assign rd_bank_busy = (state_q == RD_DRAIN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RD_IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every variable assigned in always_comb gets a default first, or a latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RD_IDLE:  if (blk_done) state_d = RD_DRAIN;
         RD_DRAIN: if (last_col && !blk_done) state_d = RD_IDLE;
         default:  state_d = RD_IDLE;
      endcase
      if (clear) state_d = RD_IDLE;
   end

   always_comb begin
      sel      = dir_q ? (LAST - rd_cnt) : rd_cnt;
      col_word = '0;
      for (int k = 0; k < N; k++) col_word[k*EW +: EW] = bank[rd_bank][k][sel*EW +: EW];
`ifdef TRANSPOSER_BYPASS_EN
      if (bypass_q) col_word = bank[rd_bank][sel];
`endif
   end

   // NOTE: the banks are plain storage with no reset; the full flags alone say what is valid.
   always_ff @(posedge clk) begin
      if (accept) bank[wr_bank][wr_cnt] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         wr_bank   <= 1'b0;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         full      <= '0;
         rd_bank   <= 1'b0;
         dir_q     <= 1'b0;
         ovf       <= 1'b0;
`ifdef TRANSPOSER_BYPASS_EN
         bypass_q  <= 1'b0;
`endif
      end else if (clear) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         wr_bank   <= 1'b0;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         full      <= '0;
         rd_bank   <= 1'b0;
         dir_q     <= 1'b0;
         ovf       <= 1'b0;
`ifdef TRANSPOSER_BYPASS_EN
         bypass_q  <= 1'b0;
`endif
      end else begin
         if (in_valid && full[wr_bank]) ovf <= 1'b1;
         if (accept) wr_cnt <= wr_cnt + 1'b1;
         if (state_q == RD_DRAIN) begin
            out_valid <= 1'b1;
            out_data  <= col_word;
            rd_cnt    <= rd_cnt + 1'b1;
         end else begin
            out_valid <= 1'b0;
            out_data  <= '0;
         end
         if (last_col) begin
            full[rd_bank] <= 1'b0;
            rd_cnt        <= '0;
         end
         if (blk_done) begin
            full[wr_bank] <= 1'b1;
            wr_bank       <= ~wr_bank;
         end
         if (load) begin
            rd_bank  <= wr_bank;
            dir_q    <= dir;
`ifdef TRANSPOSER_BYPASS_EN
            bypass_q <= bypass;
`endif
         end
      end
   end

   // Writing into a bank that has not drained yet means the upstream broke the rate contract.
   ovf_never_set: assert property (@(posedge clk) disable iff (!rst_n) !ovf);

endmodule

// File: tb/tb_pingpong_transposer.sv
// Bench for pingpong_transposer: queue-based block model checked every cycle plus literal pins.
// Define TRANSPOSER_BYPASS_EN to also exercise the bypass port.
module tb_pingpong_transposer;

   typedef logic [63:0] blk_t [4];
   typedef struct {
      logic [63:0] w;
      int unsigned e;
   } exp_t;

   logic        clk, rst_n, clear, in_valid, dir;
   logic [63:0] in_data;
   logic        out_valid, wr_bank, rd_bank_busy;
   logic [63:0] out_data;
`ifdef TRANSPOSER_BYPASS_EN
   logic        bypass;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   pingpong_transposer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clear),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .dir          (dir),
`ifdef TRANSPOSER_BYPASS_EN
      .bypass       (bypass),
`endif
      .out_valid    (out_valid),
      .out_data     (out_data),
      .wr_bank      (wr_bank),
      .rd_bank_busy (rd_bank_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: collect rows of each block, and on completion schedule the N transposed words
   // on the following N clock edges.
   exp_t        exp_q[$];
   logic [63:0] m_rows [4];
   int          m_cnt;
   logic        m_wb;
   int unsigned cyc = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         m_cnt = 0;
         m_wb  = 1'b0;
      end else begin
         cyc++;
         if (clear) begin
            exp_q.delete();
            m_cnt = 0;
            m_wb  = 1'b0;
         end else if (in_valid) begin
            m_rows[m_cnt] = in_data;
            m_cnt++;
            if (m_cnt == 4) begin
               logic byp;
               byp = 1'b0;
`ifdef TRANSPOSER_BYPASS_EN
               byp = bypass;
`endif
               m_cnt = 0;
               m_wb  = ~m_wb;
               for (int j = 0; j < 4; j++) begin
                  int   c;
                  exp_t x;
                  c = dir ? 3 - j : j;
                  if (byp) x.w = m_rows[c];
                  else for (int r = 0; r < 4; r++) x.w[r*16 +: 16] = m_rows[r][c*16 +: 16];
                  x.e = cyc + j + 1;
                  exp_q.push_back(x);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      logic        ev, eb;
      logic [63:0] ew;
      if (rst_n) begin
         ev = 1'b0;
         ew = '0;
         if (exp_q.size() > 0 && exp_q[0].e == cyc) begin
            ev = 1'b1;
            ew = exp_q[0].w;
            void'(exp_q.pop_front());
         end
         eb = (exp_q.size() > 0);
         check("stream_valid", {63'd0, out_valid}, {63'd0, ev});
         check("stream_data", out_data, ew);
         check("stream_wr_bank", {63'd0, wr_bank}, {63'd0, m_wb});
         check("stream_busy", {63'd0, rd_bank_busy}, {63'd0, eb});
      end
   end

   blk_t blk_a, blk_b;
   logic [63:0] col_a [4];

   task automatic send_block(input blk_t b);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = b[i];
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      blk_a = '{64'h0003000200010000, 64'h0007000600050004,
                64'h000B000A00090008, 64'h000F000E000D000C};
      for (int i = 0; i < 4; i++) blk_b[i] = blk_a[i] + 64'h0010001000100010;
      col_a = '{64'h000C000800040000, 64'h000D000900050001,
                64'h000E000A00060002, 64'h000F000B00070003};

      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; dir = 1'b0;
`ifdef TRANSPOSER_BYPASS_EN
      bypass = 1'b0;
`endif
      #3;
      check("reset_valid", {63'd0, out_valid}, 64'd0);
      check("reset_data", out_data, 64'd0);
      check("reset_wr_bank", {63'd0, wr_bank}, 64'd0);
      check("reset_busy", {63'd0, rd_bank_busy}, 64'd0);
      idle(2);
      rst_n = 1'b1;
      idle(2);

      // Transpose, ascending columns.
      send_block(blk_a);
      check("t1_latency", {63'd0, out_valid}, 64'd0);
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check("t1_valid", {63'd0, out_valid}, 64'd1);
         check("t1_col", out_data, col_a[j]);
      end
      @(negedge clk);
      check("t1_end", {63'd0, out_valid}, 64'd0);
      idle(2);

      // Descending columns; dir flips mid-drain and must not matter.
      dir = 1'b1;
      send_block(blk_a);
      dir = 1'b0;
      @(negedge clk);
      check("t2_first", out_data, col_a[3]);
      idle(2);
      @(negedge clk);
      check("t2_last", out_data, col_a[0]);
      idle(3);

      // Two back-to-back blocks: no bubble between them.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 4) check("t3_wr_bank1", {63'd0, wr_bank}, 64'd1);
         in_valid = 1'b1;
         in_data  = (i < 4) ? blk_a[i] : blk_b[i-4];
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
      check("t3_wr_bank0", {63'd0, wr_bank}, 64'd0);
      check("t3_a_col3", out_data, 64'h000F000B00070003);
      @(negedge clk);
      check("t3_b_valid", {63'd0, out_valid}, 64'd1);
      check("t3_b_col0", out_data, 64'h001C001800140010);
      idle(6);

      // Gapped input.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = blk_a[i];
      end
      for (int g = 0; g < 3; g++) begin
         @(negedge clk);
         in_valid = 1'b0;
         check("t4_gap_idle", {63'd0, out_valid}, 64'd0);
      end
      for (int i = 2; i < 4; i++) begin
         @(negedge clk);
         check("t4_wait_idle", {63'd0, out_valid}, 64'd0);
         in_valid = 1'b1;
         in_data  = blk_a[i];
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("t4_latency", {63'd0, out_valid}, 64'd0);
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check("t4_col", out_data, col_a[j]);
      end
      idle(3);

      // Clear mid-block discards the partial block and the word presented with it.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = blk_b[i];
      end
      @(negedge clk);
      clear   = 1'b1;
      in_data = blk_b[2];
      @(negedge clk);
      clear    = 1'b0;
      in_valid = 1'b0;
      check("t5_clear_wr_bank", {63'd0, wr_bank}, 64'd0);
      send_block(blk_a);
      @(negedge clk);
      check("t5_col0", out_data, col_a[0]);

      // Asynchronous reset during drain drops outputs at once.
      #1 rst_n = 1'b0;
      #1;
      check("t5_rst_valid", {63'd0, out_valid}, 64'd0);
      check("t5_rst_data", out_data, 64'd0);
      check("t5_rst_busy", {63'd0, rd_bank_busy}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      dir = 1'b1;
      send_block(blk_b);
      dir = 1'b0;
      @(negedge clk);
      check("t5_recover", out_data, 64'h001F001B00170013);
      idle(6);

`ifdef TRANSPOSER_BYPASS_EN
      bypass = 1'b1;
      send_block(blk_a);
      bypass = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check("t6_bypass_row", out_data, blk_a[j]);
      end
      idle(3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
